// File: rtl/memory_dp_be.sv
// rtl/memory_dp_be.sv - true dual-port RAM with byte enables, RDW mode and post-reset clear
//
// Purpose:
//   Shared scratch/buffer store for two independent masters on one clock.
//   After reset a clear sequencer optionally zeroes every word. Requests
//   are ignored until `ready` rises.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   a_en / b_en           port request this cycle
//   a_wr / b_wr           1 = write, 0 = read (qualified by *_en)
//   a_be / b_be           byte-lane write enables
//   a_addr / b_addr       word address
//   a_din / b_din         write data
//   a_dout / b_dout       registered read data (held when not reading)
//   a_valid / b_valid     one-cycle strobe: *_dout carries fresh read data
//   ready                 block accepts requests
//   collision             one-cycle strobe: same-address write-write overlap on a lane
module memory_dp_be #(
  parameter int ADDR           = 4,
  parameter int DATA           = 8,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BE            = DATA / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_en,
  input  logic            a_wr,
  input  logic [BE-1:0]   a_be,
  input  logic [ADDR-1:0] a_addr,
  input  logic [DATA-1:0] a_din,
  output logic [DATA-1:0] a_dout,
  output logic            a_valid,
  input  logic            b_en,
  input  logic            b_wr,
  input  logic [BE-1:0]   b_be,
  input  logic [ADDR-1:0] b_addr,
  input  logic [DATA-1:0] b_din,
  output logic [DATA-1:0] b_dout,
  output logic            b_valid,
  output logic            ready,
  output logic            collision
);

  localparam int DEPTH = 1 << ADDR;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [ADDR-1:0] cnt, cnt_next;
  logic            clear_we;

  logic [DATA-1:0] mem [DEPTH];

  logic            run;
  logic            a_rd, a_we, b_rd, b_we;
  logic            same_addr;
  logic [BE-1:0]   a_lane_we, b_lane_we;
  logic            collide;
  logic [DATA-1:0] a_rd_word, b_rd_word;

  // Replace the lanes selected by mask with new data, keep the rest.
  function automatic logic [DATA-1:0] lane_merge(input logic [DATA-1:0] old_w,
                                                 input logic [DATA-1:0] new_w,
                                                 input logic [BE-1:0]   mask);
    logic [DATA-1:0] r;
    r = old_w;
    for (int i = 0; i < BE; i++) begin
      if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Clear sequencer / run-state FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clear_we   = 1'b0;
    case (state)
      S_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          clear_we = 1'b1;
          cnt_next = cnt + 1'b1;
          if (cnt == ADDR'(DEPTH - 1)) state_next = S_RUN;
        end else begin
          state_next = S_RUN;
        end
      end
      S_RUN:   state_next = S_RUN;
      default: state_next = S_CLEAR;
    endcase
  end

  assign ready = (state == S_RUN);
  assign run   = ready;

  // ---------------------------------------------------------------------
  // Request decode and collision resolution
  // ---------------------------------------------------------------------
  assign a_rd      = run && a_en && !a_wr;
  assign a_we      = run && a_en &&  a_wr;
  assign b_rd      = run && b_en && !b_wr;
  assign b_we      = run && b_en &&  b_wr;
  assign same_addr = (a_addr == b_addr);

  // Port A owns any lane both ports write at the same address; B keeps
  // only the lanes A left alone, so the array never sees two writers on
  // one lane.
  assign a_lane_we = a_we ? a_be : '0;
  assign b_lane_we = b_we ? (b_be & ~(same_addr ? a_lane_we : '0)) : '0;
  assign collide   = a_we && b_we && same_addr && ((a_be & b_be) != '0);

  // Read data: array word (pre-write), optionally bypassed with the other
  // port's enabled write lanes when reading the address being written.
  always_comb begin
    a_rd_word = mem[a_addr];
    b_rd_word = mem[b_addr];
    if (RDW_MODE != 0) begin
      if (b_we && same_addr) a_rd_word = lane_merge(mem[a_addr], b_din, b_be);
      if (a_we && same_addr) b_rd_word = lane_merge(mem[b_addr], a_din, a_be);
    end
  end

  // ---------------------------------------------------------------------
  // Array write. No reset: contents survive reset unless cleared. While
  // reset is held the FSM sits in CLEAR, so port writes are blocked; the
  // only activity is zeroing word 0, which the clear redoes anyway.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clear_we) mem[cnt] <= '0;
    for (int i = 0; i < BE; i++) begin
      if (a_lane_we[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
      if (b_lane_we[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dout    <= '0;
      b_dout    <= '0;
      a_valid   <= 1'b0;
      b_valid   <= 1'b0;
      collision <= 1'b0;
    end else begin
      a_valid   <= a_rd;
      b_valid   <= b_rd;
      collision <= collide;
      if (a_rd) a_dout <= a_rd_word;
      if (b_rd) b_dout <= b_rd_word;
    end
  end

endmodule

// File: tb/tb_memory_dp_be.sv
// tb/tb_memory_dp_be.sv - self-checking bench for memory_dp_be (two configurations)
module tb_memory_dp_be;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst0_n, rst1_n;
  logic          a_en, a_wr, b_en, b_wr;
  logic [NB-1:0] a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;

  logic [1:0][DW-1:0] a_dout, b_dout;
  logic [1:0]         a_valid, b_valid, ready, collision;

  // u0: old-data read-during-write, clear after reset
  memory_dp_be #(.ADDR(AW), .DATA(DW), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst_n(rst0_n),
    .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout[0]), .a_valid(a_valid[0]),
    .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout[0]), .b_valid(b_valid[0]),
    .ready(ready[0]), .collision(collision[0])
  );

  // u1: bypass read-during-write, no clear
  memory_dp_be #(.ADDR(AW), .DATA(DW), .RDW_MODE(1), .CLEAR_ON_RESET(0)) u1 (
    .clk(clk), .rst_n(rst1_n),
    .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout[1]), .a_valid(a_valid[1]),
    .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout[1]), .b_valid(b_valid[1]),
    .ready(ready[1]), .collision(collision[1])
  );

  // Reference model state per instance
  logic [DW-1:0] mm [2][DEPTH];
  logic [DW-1:0] e_adout [2];
  logic [DW-1:0] e_bdout [2];
  bit            e_av [2];
  bit            e_bv [2];
  bit            e_col [2];
  bit            e_rdy [2];
  int            edges [2];
  bit            clr_mode [2] = '{1'b1, 1'b0};
  bit            rdw_mode [2] = '{1'b0, 1'b1};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d ready", k),     32'(ready[k]),     32'(e_rdy[k]));
      chk($sformatf("u%0d a_valid", k),   32'(a_valid[k]),   32'(e_av[k]));
      chk($sformatf("u%0d b_valid", k),   32'(b_valid[k]),   32'(e_bv[k]));
      chk($sformatf("u%0d a_dout", k),    32'(a_dout[k]),    32'(e_adout[k]));
      chk($sformatf("u%0d b_dout", k),    32'(b_dout[k]),    32'(e_bdout[k]));
      chk($sformatf("u%0d collision", k), 32'(collision[k]), 32'(e_col[k]));
    end
  endtask

  // Advance model k by one rising edge using the current inputs.
  task automatic model_edge(input int k);
    logic [DW-1:0] nw [DEPTH];
    bit r, aw, bw, ar, br;
    r = (k == 0) ? rst0_n : rst1_n;
    if (!r) return;
    if (!e_rdy[k]) begin
      e_av[k] = 0; e_bv[k] = 0; e_col[k] = 0;
      edges[k]++;
      if (!clr_mode[k] || edges[k] == DEPTH) begin
        e_rdy[k] = 1;
        if (clr_mode[k]) for (int i = 0; i < DEPTH; i++) mm[k][i] = '0;
      end
      return;
    end
    aw = a_en && a_wr;  ar = a_en && !a_wr;
    bw = b_en && b_wr;  br = b_en && !b_wr;
    for (int i = 0; i < DEPTH; i++) nw[i] = mm[k][i];
    for (int l = 0; l < NB; l++) begin
      if (bw && b_be[l]) nw[b_addr][8*l +: 8] = b_din[8*l +: 8];
    end
    for (int l = 0; l < NB; l++) begin
      if (aw && a_be[l]) nw[a_addr][8*l +: 8] = a_din[8*l +: 8];
    end
    e_col[k] = aw && bw && (a_addr == b_addr) && ((a_be & b_be) != 0);
    e_av[k]  = ar;
    e_bv[k]  = br;
    if (ar) e_adout[k] = rdw_mode[k] ? nw[a_addr] : mm[k][a_addr];
    if (br) e_bdout[k] = rdw_mode[k] ? nw[b_addr] : mm[k][b_addr];
    for (int i = 0; i < DEPTH; i++) mm[k][i] = nw[i];
  endtask

  task automatic step();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic set_rst(input int k, input bit v);
    if (k == 0) rst0_n = v; else rst1_n = v;
    #1;
    if (!v) begin
      e_rdy[k] = 0; edges[k] = 0;
      e_av[k] = 0; e_bv[k] = 0; e_col[k] = 0;
      e_adout[k] = '0; e_bdout[k] = '0;
      check_outs();
    end
  endtask

  task automatic pa(input bit en, input bit wr, input int addr, input int be, input int din);
    a_en = en; a_wr = wr; a_addr = AW'(addr); a_be = NB'(be); a_din = DW'(din);
  endtask

  task automatic pb(input bit en, input bit wr, input int addr, input int be, input int din);
    b_en = en; b_wr = wr; b_addr = AW'(addr); b_be = NB'(be); b_din = DW'(din);
  endtask

  task automatic idle();
    pa(0, 0, 0, 0, 0);
    pb(0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) mm[k][i] = '0;
    idle();
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    #1;
    set_rst(0, 0);
    set_rst(1, 0);
    step();
    step();

    // Clear sequence on u0: ready exactly after the 16th edge
    set_rst(0, 1);
    repeat (15) step();
    chk("ready_before_16", 32'(ready[0]), 32'd0);
    step();
    chk("ready_at_16", 32'(ready[0]), 32'd1);

    // Pre-load word 5, then reset and clear again with requests pending
    pa(1, 1, 5, 3, 'hBEEF); step();
    pa(1, 0, 5, 0, 0);      step();
    chk("preload", 32'(a_dout[0]), 32'hBEEF);
    idle();
    set_rst(0, 0);
    step();
    set_rst(0, 1);
    pa(1, 0, 5, 0, 0); pb(1, 1, 5, 3, 'h1234);
    repeat (16) step();
    idle(); pa(1, 0, 5, 0, 0);
    step();
    chk("clear_read", 32'(a_dout[0]), 32'h0000);
    chk("clear_read_valid", 32'(a_valid[0]), 32'd1);

    // Bring up u1 and fill every word of both instances
    idle();
    set_rst(1, 1);
    step();
    chk("u1_ready_first_edge", 32'(ready[1]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      pa(1, 1, i, 3, int'($urandom));
      pb(1, 1, i + 8, 3, int'($urandom));
      step();
    end

    // Byte enables
    idle();
    pa(1, 1, 3, 3, 'hAABB); step();
    pa(1, 1, 3, 1, 'h1122); step();
    pa(1, 0, 3, 0, 0);      step();
    chk("be_merge", 32'(a_dout[0]), 32'hAA22);
    pa(1, 1, 3, 0, 'h5555); step();
    pa(1, 0, 3, 0, 0);      step();
    chk("be_zero_noop", 32'(a_dout[0]), 32'hAA22);

    // Independent dual-port access
    pa(1, 1, 3, 3, 234); pb(1, 1, 15, 3, 255); step();
    pa(1, 0, 15, 0, 0);  pb(1, 0, 3, 0, 0);    step();
    chk("dp_a_dout", 32'(a_dout[0]), 32'd255);
    chk("dp_b_dout", 32'(b_dout[0]), 32'd234);
    chk("dp_collision", 32'(collision[0]), 32'd0);

    // Write-write collision at address 0
    pa(1, 1, 0, 3, 'h1111); pb(1, 1, 0, 3, 'h2222); step();
    chk("collision_full", 32'(collision[0]), 32'd1);
    idle(); pa(1, 0, 0, 0, 0); step();
    chk("collision_one_cycle", 32'(collision[0]), 32'd0);
    chk("collision_readback", 32'(a_dout[0]), 32'h1111);
    pa(1, 1, 0, 1, 'h1111); pb(1, 1, 0, 2, 'h2222); step();
    chk("collision_disjoint", 32'(collision[0]), 32'd0);
    idle(); pa(1, 0, 0, 0, 0); step();
    chk("disjoint_readback", 32'(a_dout[0]), 32'h2211);

    // Read-during-write across ports
    idle(); pa(1, 1, 7, 3, 'h0001); step();
    pa(1, 1, 7, 3, 'h00FF); pb(1, 0, 7, 0, 0); step();
    chk("rdw_old", 32'(b_dout[0]), 32'h0001);
    chk("rdw_new", 32'(b_dout[1]), 32'h00FF);

    // Back-to-back reads
    idle();
    for (int i = 0; i < 6; i++) begin
      pa(1, 0, i, 0, 0); pb(1, 0, 15 - i, 0, 0); step();
    end

    // Reset mid-clear on u0: clear restarts from scratch
    idle();
    set_rst(0, 0); step(); set_rst(0, 1);
    repeat (8) step();
    set_rst(0, 0); step(); set_rst(0, 1);
    repeat (15) step();
    chk("restart_not_ready", 32'(ready[0]), 32'd0);
    step();
    chk("restart_ready", 32'(ready[0]), 32'd1);

    // u1 keeps its contents across reset
    pa(1, 1, 9, 3, 'hC0DE); step();
    idle();
    set_rst(1, 0); step(); set_rst(1, 1);
    step();
    chk("noclr_ready", 32'(ready[1]), 32'd1);
    pa(1, 0, 9, 0, 0); step();
    chk("noclr_preserved", 32'(a_dout[1]), 32'hC0DE);

    // Randomized traffic on a narrow address window to force overlaps
    repeat (400) begin
      pa($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
         int'($urandom_range(0, 3)), int'($urandom));
      pb($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
         int'($urandom_range(0, 3)), int'($urandom));
      step();
    end

    idle();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
